// File: rtl/disp_bcd_feed_pkg.sv
// Shared types and constants for the display BCD feeder.
package disp_bcd_feed_pkg;
  localparam int BIN_W      = 14;
  localparam int BCD_DIGITS = 4;
  localparam int SAT_LIMIT  = 9999;
  // One spare digit so 16383 converts without loss
  localparam int ACC_DIGITS = BCD_DIGITS + 1;
  localparam int ACC_W      = 4 * ACC_DIGITS;
  localparam int NUM_HEX    = 2 * BCD_DIGITS;

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;
  typedef logic [3:0] bcd_t;
endpackage

// File: rtl/disp_bcd_feed_if.sv
// Load/value inputs and frame outputs of the feeder; master drives load, slave is the feeder.
interface disp_bcd_feed_if;
  import disp_bcd_feed_pkg::*;
  logic             load;
  logic [BIN_W-1:0] val_a;
  logic [BIN_W-1:0] val_b;
  bcd_t             hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic [7:0]       dp_out;
  logic             busy;
  logic             done;
  logic [1:0]       ovf;

  modport master (output load, val_a, val_b,
                  input  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7, dp_out, busy, done, ovf);
  modport slave  (input  load, val_a, val_b,
                  output hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7, dp_out, busy, done, ovf);
endinterface

// File: rtl/disp_bcd_feed_bin2bcd_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift {acc, sr} left by one.
module bin2bcd_step
  import disp_bcd_feed_pkg::*;
(
  input  logic [ACC_W-1:0] acc_i,
  input  logic [BIN_W-1:0] sr_i,
  output logic [ACC_W-1:0] acc_o,
  output logic [BIN_W-1:0] sr_o
);
  logic [ACC_W-1:0] adj;

  for (genvar d = 0; d < ACC_DIGITS; d++) begin : g_dig
    assign adj[4*d +: 4] = (acc_i[4*d +: 4] >= 4'd5) ? acc_i[4*d +: 4] + 4'd3 : acc_i[4*d +: 4];
  end

  assign {acc_o, sr_o} = {adj, sr_i} << 1;
endmodule

// File: rtl/disp_bcd_feed.sv
// Captures two binary amounts, converts them to BCD in 14 cycles and commits one frame at once.
// Optional DISP_SAT_EN: values above 9999 show as 9999 and raise ovf.
module disp_bcd_feed
  import disp_bcd_feed_pkg::*;
#(
  parameter logic [7:0] DP_MASK = 8'b1101_1101
) (
  input  logic           clk,
  input  logic           rst_n,
  disp_bcd_feed_if.slave bus
);
  state_t                          state_q;
  logic [3:0]                      cnt_q;
  logic [BIN_W-1:0]                sr_a_q, sr_b_q, sr_a_n, sr_b_n;
  logic [ACC_W-1:0]                acc_a_q, acc_b_q, acc_a_n, acc_b_n;
  logic [NUM_HEX-1:0][3:0]         hex_q, frame_d;
  logic [1:0]                      ovf_q, ovf_d;
  logic                            busy_q, done_q;
  logic [7:0]                      dp_q;

  bin2bcd_step u_step_a (.acc_i(acc_a_q), .sr_i(sr_a_q), .acc_o(acc_a_n), .sr_o(sr_a_n));
  bin2bcd_step u_step_b (.acc_i(acc_b_q), .sr_i(sr_b_q), .acc_o(acc_b_n), .sr_o(sr_b_n));

`ifdef DISP_SAT_EN
  always_comb begin
    ovf_d        = {|acc_b_q[ACC_W-1 -: 4], |acc_a_q[ACC_W-1 -: 4]};
    frame_d[3:0] = ovf_d[0] ? {4{4'd9}} : acc_a_q[15:0];
    frame_d[7:4] = ovf_d[1] ? {4{4'd9}} : acc_b_q[15:0];
  end
`else
  // Ten-thousands digit only feeds the conversion; the display wraps mod 10000.
  logic unused_tth;
  assign unused_tth = ^{acc_a_q[ACC_W-1 -: 4], acc_b_q[ACC_W-1 -: 4]};
  always_comb begin
    ovf_d   = 2'b00;
    frame_d = {acc_b_q[15:0], acc_a_q[15:0]};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_a_q  <= '0;
      sr_b_q  <= '0;
      acc_a_q <= '0;
      acc_b_q <= '0;
      hex_q   <= '0;
      ovf_q   <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dp_q    <= 8'hFF;
    end else begin
      dp_q   <= DP_MASK;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.load) begin
          sr_a_q  <= bus.val_a;
          sr_b_q  <= bus.val_b;
          acc_a_q <= '0;
          acc_b_q <= '0;
          cnt_q   <= 4'(BIN_W - 1);
          busy_q  <= 1'b1;
          state_q <= CONVERT;
        end
        CONVERT: begin
          acc_a_q <= acc_a_n;
          acc_b_q <= acc_b_n;
          sr_a_q  <= sr_a_n;
          sr_b_q  <= sr_b_n;
          if (cnt_q == 4'd0) state_q <= COMMIT;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        COMMIT: begin
          hex_q   <= frame_d;
          ovf_q   <= ovf_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.hex0   = hex_q[0];
  assign bus.hex1   = hex_q[1];
  assign bus.hex2   = hex_q[2];
  assign bus.hex3   = hex_q[3];
  assign bus.hex4   = hex_q[4];
  assign bus.hex5   = hex_q[5];
  assign bus.hex6   = hex_q[6];
  assign bus.hex7   = hex_q[7];
  assign bus.ovf    = ovf_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.dp_out = dp_q;
endmodule

// File: tb/tb_disp_bcd_feed.sv
// Self-checking bench for disp_bcd_feed: vector table, corner sequences and random frames vs a decimal model.
module tb_disp_bcd_feed;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  disp_bcd_feed_if f ();
  disp_bcd_feed dut (.clk(clk), .rst_n(rst_n), .bus(f));

  always #5 clk = ~clk;

  typedef struct {
    int          a;
    int          b;
    logic [31:0] hex;
    logic [1:0]  ovf;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_hex();
    return {f.hex7, f.hex6, f.hex5, f.hex4, f.hex3, f.hex2, f.hex1, f.hex0};
  endfunction

  // Decimal reference: digits of one amount as shown on the display.
  function automatic logic [15:0] show(input int v, output logic o);
    int w;
    logic [15:0] r;
    o = 1'b0;
    w = v % 10000;
`ifdef DISP_SAT_EN
    if (v > 9999) begin o = 1'b1; w = 9999; end
`endif
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(w % 10);
      w = w / 10;
    end
    return r;
  endfunction

  // Load a frame, check the 14 quiet cycles, then the commit cycle.
  task automatic run_frame(input int a, input int b, input logic [31:0] eh,
                           input logic [1:0] eo, input bit inj, input string nm);
    logic [31:0] h0;
    bit ok;
    logic [13:0] ta, tb;
    ta = a[13:0];
    tb = b[13:0];
    h0 = dut_hex();
    @(negedge clk);
    f.load = 1'b1; f.val_a = ta; f.val_b = tb;
    @(posedge clk); #1;
    f.load = 1'b0; f.val_a = 14'($urandom); f.val_b = 14'($urandom);
    chk({nm, "_busy_T"}, {31'd0, f.busy}, 32'd1);
    ok = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (inj && k == 5) begin
        f.load = 1'b1; f.val_a = 14'd7777; f.val_b = 14'd7777;
      end
      @(posedge clk); #1;
      f.load = 1'b0;
      if (f.done !== 1'b0 || f.busy !== 1'b1 || dut_hex() !== h0) ok = 1'b0;
    end
    chk({nm, "_window"}, {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    chk({nm, "_done"}, {30'd0, f.done, f.busy}, 32'd2);
    chk({nm, "_hex"}, dut_hex(), eh);
    chk({nm, "_ovf"}, {30'd0, f.ovf}, {30'd0, eo});
    chk({nm, "_dp"}, {24'd0, f.dp_out}, 32'h0000_00DD);
  endtask

  vec_t tbl[5];

  initial begin
    logic [15:0] ha, hb;
    logic oa, ob;
    int ra, rb;
    bit ok;

    tbl[0] = '{1234, 50, 32'h0050_1234, 2'b00};
    tbl[1] = '{0, 9999, 32'h9999_0000, 2'b00};
`ifdef DISP_SAT_EN
    tbl[2] = '{12000, 16383, 32'h9999_9999, 2'b11};
    tbl[3] = '{10000, 9998, 32'h9998_9999, 2'b01};
`else
    tbl[2] = '{12000, 16383, 32'h6383_2000, 2'b00};
    tbl[3] = '{10000, 9998, 32'h9998_0000, 2'b00};
`endif
    tbl[4] = '{7, 1000, 32'h1000_0007, 2'b00};

    f.load = 1'b0; f.val_a = '0; f.val_b = '0;
    #12;
    chk("rst_hex", dut_hex(), 32'h0);
    chk("rst_flags", {28'd0, f.busy, f.done, f.ovf}, 32'd0);
    chk("rst_dp", {24'd0, f.dp_out}, 32'h0000_00FF);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("dp_after_rst", {24'd0, f.dp_out}, 32'h0000_00DD);

    for (int i = 0; i < 5; i++)
      run_frame(tbl[i].a, tbl[i].b, tbl[i].hex, tbl[i].ovf, 1'b0, $sformatf("vec%0d", i));

    // Load while busy is dropped; nothing restarts afterwards.
    run_frame(1234, 50, 32'h0050_1234, 2'b00, 1'b1, "ignore");
    ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (f.done !== 1'b0 || f.busy !== 1'b0) ok = 1'b0;
    end
    chk("ignore_quiet", {31'd0, ok}, 32'd1);

    // Second load in the done cycle is accepted.
    run_frame(5, 6, 32'h0006_0005, 2'b00, 1'b0, "b2b_first");
    run_frame(4321, 100, 32'h0100_4321, 2'b00, 1'b0, "b2b_second");

    // Reset in the middle of a conversion.
    run_frame(1234, 50, 32'h0050_1234, 2'b00, 1'b0, "pre_rst");
    @(negedge clk);
    f.load = 1'b1; f.val_a = 14'd5678; f.val_b = 14'd5678;
    @(posedge clk); #1;
    f.load = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_hex", dut_hex(), 32'h0);
    chk("midrst_flags", {28'd0, f.busy, f.done, f.ovf}, 32'd0);
    chk("midrst_dp", {24'd0, f.dp_out}, 32'h0000_00FF);
    ok = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (f.done !== 1'b0 || f.busy !== 1'b0) ok = 1'b0;
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (16) begin
      @(posedge clk); #1;
      if (f.done !== 1'b0 || f.busy !== 1'b0) ok = 1'b0;
    end
    chk("midrst_no_done", {31'd0, ok}, 32'd1);
    run_frame(5678, 5678, 32'h5678_5678, 2'b00, 1'b0, "post_rst");

    // Random frames checked against the decimal model.
    for (int i = 0; i < 40; i++) begin
      ra = (i % 8 == 0) ? 16383 : int'($urandom_range(0, 16383));
      rb = (i % 8 == 1) ? 0     : int'($urandom_range(0, 16383));
      ha = show(ra, oa);
      hb = show(rb, ob);
      run_frame(ra, rb, {hb, ha}, {ob, oa}, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
